// File: rtl/onehot_to_bin_enc.sv
// Registered one-hot to binary encoder with illegal-word flagging and a
// saturating count of illegal words accepted.
module onehot_to_bin_enc #(
  parameter int N  = 4,
  parameter int W  = $clog2(N),
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_onehot,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_bin,
  output logic          out_err,
  output logic [CW-1:0] err_cnt
);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // in_ready = !out_valid || out_ready, so a full register can be drained
  // and refilled in the same cycle.
  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           w_in_xfer;
  logic           w_out_xfer;
  logic [W-1:0]   w_idx;
  logic           w_any;
  logic           w_multi;
  logic           w_illegal;
  logic [W-1:0]   r_bin;
  logic           r_err;
  logic [CW-1:0]  r_err_cnt;

  assign out_valid  = (r_state == S_FULL);
  assign in_ready   = !out_valid || out_ready;
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready;

  // Downward scan leaves the lowest set bit's index in w_idx.
  always_comb begin
    w_idx   = '0;
    w_any   = 1'b0;
    w_multi = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (in_onehot[i]) begin
        w_idx = W'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (in_onehot[i]) begin
        if (w_any) begin
          w_multi = 1'b1;
        end
        w_any = 1'b1;
      end
    end
  end

  assign w_illegal = !w_any || w_multi;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_in_xfer) w_state_nxt = S_FULL;
      S_FULL:  if (w_out_xfer && !w_in_xfer) w_state_nxt = S_EMPTY;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counting follows input acceptance so a stalled consumer never skews it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin     <= '0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else if (w_in_xfer) begin
      r_bin <= w_idx;
      r_err <= w_illegal;
      if (w_illegal && (r_err_cnt != {CW{1'b1}})) begin
        r_err_cnt <= r_err_cnt + CW'(1);
      end
    end
  end

  assign out_bin = r_bin;
  assign out_err = r_err;
  assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_onehot_to_bin_enc.sv
// Bench for onehot_to_bin_enc: vector table, hand-written handshake/reset
// sequences, and randomized traffic against a behavioural model.
module tb_onehot_to_bin_enc;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_onehot;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_bin;
  logic       out_err;
  logic [7:0] err_cnt;

  logic       s_in_ready;
  logic       s_out_valid;
  logic [1:0] s_out_bin;
  logic       s_out_err;
  logic [1:0] s_err_cnt;

  int checks;
  int errors;

  onehot_to_bin_enc #(.N(4), .CW(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_onehot (in_onehot),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bin   (out_bin),
    .out_err   (out_err),
    .err_cnt   (err_cnt)
  );

  onehot_to_bin_enc #(.N(4), .CW(2)) u_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (s_in_ready),
    .in_onehot (in_onehot),
    .out_valid (s_out_valid),
    .out_ready (out_ready),
    .out_bin   (s_out_bin),
    .out_err   (s_out_err),
    .err_cnt   (s_err_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] oh;
    logic [1:0] bin;
    logic       err;
  } vec_t;

  vec_t vecs[8];
  logic [2:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive at a negedge, advance one clock, return at the next negedge.
  task automatic drive(input logic v, input logic [3:0] oh, input logic rdy);
    in_valid  = v;
    in_onehot = oh;
    out_ready = rdy;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference: legality from popcount, index from isolated lowest bit.
  function automatic logic [2:0] ref_enc(input logic [3:0] x);
    logic [3:0] lsb;
    int         idx;
    lsb = x & (~x + 4'd1);
    idx = (x == 4'd0) ? 0 : $clog2(lsb);
    return {($countones(x) != 1), idx[1:0]};
  endfunction

  initial begin
    int exp_cnt;
    int mcnt;
    logic exp_rdy;
    logic [2:0] r;
    checks = 0;
    errors = 0;

    vecs[0] = '{4'b0001, 2'd0, 1'b0};
    vecs[1] = '{4'b0010, 2'd1, 1'b0};
    vecs[2] = '{4'b0100, 2'd2, 1'b0};
    vecs[3] = '{4'b1000, 2'd3, 1'b0};
    vecs[4] = '{4'b0000, 2'd0, 1'b1};
    vecs[5] = '{4'b0110, 2'd1, 1'b1};
    vecs[6] = '{4'b1001, 2'd0, 1'b1};
    vecs[7] = '{4'b1100, 2'd2, 1'b1};

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_onehot = 4'b0000;
    out_ready = 1'b1;

    // 1: reset held for 3 clocks, then idle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
    end
    chk("rst_out_bin", out_bin, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 4'b1111, 1'b1);
      chk("idle_out_valid", out_valid, 0);
      chk("idle_in_ready", in_ready, 1);
      chk("idle_err_cnt", err_cnt, 0);
      chk("idle_out_bin", out_bin, 0);
    end

    // 2+3: table applied back to back with out_ready=1
    exp_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, vecs[i].oh, 1'b1);
      exp_cnt += int'(vecs[i].err);
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_bin", i), out_bin, vecs[i].bin);
      chk($sformatf("vec%0d_err", i), out_err, vecs[i].err);
      chk($sformatf("vec%0d_cnt", i), err_cnt, exp_cnt);
    end
    drive(1'b0, 4'b0000, 1'b1);
    chk("drain_out_valid", out_valid, 0);
    chk("drain_err_cnt", err_cnt, 4);

    // 4: backpressure, new word waits while the held result stays stable
    drive(1'b1, 4'b0100, 1'b1);
    chk("bp_first_bin", out_bin, 2);
    in_valid = 1'b1;
    in_onehot = 4'b1000;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_bin", out_bin, 2);
      chk("bp_out_err", out_err, 0);
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    chk("bp_next_valid", out_valid, 1);
    chk("bp_next_bin", out_bin, 3);
    drive(1'b0, 4'b0000, 1'b1);
    chk("bp_drain_valid", out_valid, 0);

    // 5: saturation on the CW=2 instance
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'b0000, 1'b1);
      chk("sat_cnt", s_err_cnt, (i < 3) ? i + 1 : 3);
      chk("sat_main_cnt", err_cnt, i + 1);
    end
    drive(1'b0, 4'b0000, 1'b1);

    // 6: async reset in the middle of a stall
    drive(1'b1, 4'b0011, 1'b1);
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("ar_pre_valid", out_valid, 1);
    chk("ar_pre_cnt", err_cnt, 6);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_cnt", err_cnt, 0);
    chk("ar_in_ready", in_ready, 1);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("ar_no_stale", out_valid, 0);
    end

    // 7: randomized traffic against the model
    do_reset();
    exp_q.delete();
    mcnt = 0;
    for (int c = 0; c < 400; c++) begin
      chk("rnd_valid", out_valid, (exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("rnd_bin", out_bin, exp_q[0][1:0]);
        chk("rnd_err", out_err, exp_q[0][2]);
      end
      chk("rnd_cnt", err_cnt, mcnt);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) in_onehot = 4'b0001 << $urandom_range(0, 3);
      else in_onehot = 4'($urandom_range(0, 15));
      #1;
      exp_rdy = (exp_q.size() == 0) || out_ready;
      chk("rnd_in_ready", in_ready, exp_rdy);
      if ((exp_q.size() != 0) && out_ready) void'(exp_q.pop_front());
      if (in_valid && exp_rdy) begin
        r = ref_enc(in_onehot);
        exp_q.push_back(r);
        if (r[2] && mcnt < 255) mcnt++;
      end
      @(posedge clk);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
